pipe2_datapath: RTL
===================

Name: pipe2_datapath

Overview:
- Parametrised two-stage (fetch / execute) successor to the single-cycle RV32I datapath.
- Registers the fetched instruction and its PC in an IF/EX pipeline register.
- Redirects the PC on jumps, taken branches and traps, and flushes the wrong-path instruction.
- Stalls on a request/ready data-memory handshake. An external controller decodes the EX-stage instruction combinationally, from `op_code`/`f3`/`f7`/`flag`.

Parameters:
- XLEN, 32, datapath and register width.
- PC_W, 16, PC and instruction-address width; the PC wraps modulo 2^PC_W.
- RESET_ADDR, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle (combinational read).
- branch  in  1  taken conditional branch; the controller has already gated it with flag.
- jump  in  2  next-PC select: 00 RESET_ADDR, 01 sequential, 10 ex_pc+imm, 11 alu_res (jalr).
- reg_w  in  1  register write enable.
- alu_s  in  1  ALU srcB select: 0 rs2, 1 imm.
- alu_op  in  3  ALU operation.
- dato_s  in  2  writeback select: 00 alu, 01 load data, 10 imm, 11 ex_pc+4.
- mem_access  in  1  EX instruction is a load or store.
- mem_write  in  1  EX instruction is a store.
- dmem_req  out  1  data request.
- dmem_we  out  1  store strobe.
- dmem_addr  out  XLEN  equals alu_res.
- dmem_wdata  out  XLEN  rs2 value.
- dmem_rdata  in  XLEN  load data, valid when dmem_ready.
- dmem_ready  in  1  request completes this cycle.
- except  in  1  trap request for the EX instruction.
- trap_vec  in  PC_W  trap target.
- op_code  out  7  EX instr[6:0].
- f3  out  3  EX instr[14:12].
- f7  out  1  EX instr[30].
- flag  out  1  ALU flag.
- ex_pc  out  PC_W  PC of the EX instruction.
- ex_valid  out  1  the EX stage holds a real instruction.
- stall  out  1  pipeline is frozen this cycle.

Behaviour:

Reset
- On a clk edge with rst_n=0:
  - pc <= RESET_ADDR
  - ex_valid <= 0
  - IF/EX instr <= 0 (NOP encoding permitted).
- The register file is not cleared. x0 always reads 0; writes to x0 are ignored.
- After the reset edge: dmem_req=0, dmem_we=0, stall=0, imem_addr=RESET_ADDR.

Qualification
- reg_w, mem_access and mem_write are ANDed internally with ex_valid.
- An invalid EX slot has no architectural effect.

Normal advance (no stall, redirect or trap)
- IF/EX <= {imem_rdata, pc}, ex_valid <= 1, pc <= pc+4.
- Throughput is 1 instruction/cycle.
- Register writes occur at the clock edge that retires the instruction.
- Register-file read is combinational. Because writeback happens in EX, no RAW hazard exists.

Redirect (condition: ex_valid & (branch | jump==10 | jump==11))
- branch or jump==10: pc <= ex_pc + imm.
- jump==11: pc <= {alu_res[PC_W-1:1], 1'b0}.
- In both cases ex_valid <= 0, flushing the fetched wrong-path instruction.
- Taken penalty is 1 cycle.
- jump==00 with ex_valid: pc <= RESET_ADDR, with flush.

Memory
- dmem_req = ex_valid & mem_access & ~except.
- dmem_we = dmem_req & mem_write.
- stall = dmem_req & ~dmem_ready.
- While stalled:
  - pc, IF/EX and ex_valid hold.
  - Register write is suppressed.
  - dmem_addr and dmem_wdata are stable.
- On the dmem_ready cycle the instruction retires: load data is written (dato_s=01) and the pipeline advances.
- dmem_ready while dmem_req=0 is ignored.

Trap
- Condition: ex_valid & except.
- pc <= trap_vec, ex_valid <= 0.
- Register write, dmem_req and any redirect are suppressed.

Priority
- reset > trap > stall > redirect > advance.
- A redirecting memory instruction is not a legal encoding. If it occurs, stall wins, then the redirect is taken on the ready cycle.

Arithmetic and PC rules
- All PC adds are modulo 2^PC_W.
- Immediates are sign-extended to XLEN; the PC target uses the low PC_W bits.

Reset mid-stall
- The request is abandoned: dmem_req drops after the reset edge and no write occurs.

Optional Feature:
- Macro: PIPE2_PERF_CNT_EN.
- When defined, two additional outputs are present:
  - cycle_cnt (64-bit): increments every cycle after reset.
  - instret_cnt (64-bit): increments on each cycle where ex_valid & ~stall & ~except (retire).
- Both counters reset to 0 and wrap at 2^64.
- When not defined, neither port nor counter exists and the rest of the behaviour is identical.

Test Plan:
1. Reset then release, with RESET_ADDR=0 and imem of ADDIs: imem_addr=0 after reset, ex_valid=0. Next cycle ex_pc=0, ex_valid=1, imem_addr=4. x1..x3 are written in consecutive cycles.
2. Taken BEQ at 0x08 with imm=+16: pc=0x18 on the cycle after BEQ is in EX. The instruction fetched at 0x0C is flushed (ex_valid=0 for one cycle; its reg write does not occur).
3. LW with dmem_ready low for 2 cycles: dmem_req=1 and stall=1 for 2 cycles, pc held. On the 3rd cycle x5 = dmem_rdata = 0xDEADBEEF and the pipeline advances.
4. except asserted while a SW is in EX, trap_vec=0x100: dmem_req=0 (no store), pc=0x100 next cycle, ex_valid=0.
5. PC wrap with PC_W=16, sequential at 0xFFFC: next pc=0x0000. JALR with alu_res=0x1235 yields pc=0x1234.
6. With PIPE2_PERF_CNT_EN, run test 3 (4 retired instructions, 2 stall cycles): instret_cnt=4 and cycle_cnt is 2 greater than the stall-free run.

Source files
------------

// File: rtl/pipe2_datapath.sv
// pipe2_datapath: two-stage (fetch / execute) RV32I datapath driven by an external decoder.
// Define PIPE2_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module pipe2_datapath #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PC_W       = 16,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            branch,
  input  logic [1:0]      jump,
  input  logic            reg_w,
  input  logic            alu_s,
  input  logic [2:0]      alu_op,
  input  logic [1:0]      dato_s,
  input  logic            mem_access,
  input  logic            mem_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  input  logic            except,
  input  logic [PC_W-1:0] trap_vec,
  output logic [6:0]      op_code,
  output logic [2:0]      f3,
  output logic            f7,
  output logic            flag,
  output logic [PC_W-1:0] ex_pc,
  output logic            ex_valid,
  output logic            stall
`ifdef PIPE2_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  localparam int unsigned REG_N = 32;
  localparam int unsigned SH_W  = $clog2(XLEN);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  localparam logic [1:0] JMP_RST  = 2'b00;
  localparam logic [1:0] JMP_SEQ  = 2'b01;
  localparam logic [1:0] JMP_REL  = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;

  logic [PC_W-1:0] pc, pc_d, pc_seq, br_tgt, jalr_tgt, link_pc;
  logic [31:0]     ex_instr;
  logic            ex_valid_d, ex_load;
  logic [XLEN-1:0] regs [REG_N];

  logic [4:0]        rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0]   rs1_v, rs2_v, src_b, imm, alu_res, wb_data;
  logic signed [31:0] imm32;
  logic              trap, redirect, retire, rf_we;

  assign imem_addr = pc;
  assign op_code   = ex_instr[6:0];
  assign f3        = ex_instr[14:12];
  assign f7        = ex_instr[30];
  assign rs1_a     = ex_instr[19:15];
  assign rs2_a     = ex_instr[24:20];
  assign rd_a      = ex_instr[11:7];

  assign rs1_v = (rs1_a == 5'd0) ? '0 : regs[rs1_a];
  assign rs2_v = (rs2_a == 5'd0) ? '0 : regs[rs2_a];

  // Immediate format follows the EX opcode; sign-extended to XLEN.
  always_comb begin
    imm32 = {{20{ex_instr[31]}}, ex_instr[31:20]};
    case (ex_instr[6:0])
      7'b0100011: imm32 = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
      7'b1100011: imm32 = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7],
                           ex_instr[30:25], ex_instr[11:8], 1'b0};
      7'b0110111,
      7'b0010111: imm32 = {ex_instr[31:12], 12'b0};
      7'b1101111: imm32 = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12],
                           ex_instr[20], ex_instr[30:21], 1'b0};
      default:    imm32 = {{20{ex_instr[31]}}, ex_instr[31:20]};
    endcase
  end
  assign imm = XLEN'(imm32);

  assign src_b = alu_s ? imm : rs2_v;

  always_comb begin
    alu_res = rs1_v + src_b;
    case (alu_op)
      ALU_ADD: alu_res = rs1_v + src_b;
      ALU_SUB: alu_res = rs1_v - src_b;
      ALU_AND: alu_res = rs1_v & src_b;
      ALU_OR:  alu_res = rs1_v | src_b;
      ALU_XOR: alu_res = rs1_v ^ src_b;
      ALU_SLT: alu_res = XLEN'($signed(rs1_v) < $signed(src_b));
      ALU_SLL: alu_res = rs1_v << src_b[SH_W-1:0];
      default: alu_res = rs1_v >> src_b[SH_W-1:0];
    endcase
  end
  assign flag = (alu_res == '0);

  // Memory handshake; a trapping instruction never issues a request.
  assign dmem_req   = ex_valid & mem_access & ~except;
  assign dmem_we    = dmem_req & mem_write;
  assign dmem_addr  = alu_res;
  assign dmem_wdata = rs2_v;
  assign stall      = dmem_req & ~dmem_ready;

  assign trap     = ex_valid & except;
  assign redirect = ex_valid & (branch | (jump != JMP_SEQ));
  assign retire   = ex_valid & ~except & ~stall;
  assign rf_we    = rst_n & retire & reg_w & (rd_a != 5'd0);

  assign pc_seq   = pc + PC_W'(4);
  assign br_tgt   = ex_pc + imm[PC_W-1:0];
  assign jalr_tgt = {alu_res[PC_W-1:1], 1'b0};
  assign link_pc  = ex_pc + PC_W'(4);

  always_comb begin
    wb_data = alu_res;
    case (dato_s)
      WB_ALU:  wb_data = alu_res;
      WB_LOAD: wb_data = dmem_rdata;
      WB_IMM:  wb_data = imm;
      default: wb_data = XLEN'(link_pc);
    endcase
  end

  // Next-state: trap > stall > redirect > sequential advance.
  always_comb begin
    pc_d       = pc_seq;
    ex_load    = 1'b1;
    ex_valid_d = 1'b1;
    if (trap) begin
      pc_d       = trap_vec;
      ex_valid_d = 1'b0;
    end else if (stall) begin
      pc_d       = pc;
      ex_load    = 1'b0;
      ex_valid_d = ex_valid;
    end else if (redirect) begin
      ex_valid_d = 1'b0;
      if (branch || (jump == JMP_REL)) begin
        pc_d = br_tgt;
      end else if (jump == JMP_JALR) begin
        pc_d = jalr_tgt;
      end else begin
        pc_d = PC_W'(RESET_ADDR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= PC_W'(RESET_ADDR);
      ex_valid <= 1'b0;
      ex_instr <= '0;
      ex_pc    <= PC_W'(RESET_ADDR);
    end else begin
      pc       <= pc_d;
      ex_valid <= ex_valid_d;
      if (ex_load) begin
        ex_instr <= imem_rdata;
        ex_pc    <= pc;
      end
    end
  end

  // Register file is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (rf_we) begin
      regs[rd_a] <= wb_data;
    end
  end

  // JMP_RST is decoded by the final else of the redirect chain.
  logic unused_jmp;
  assign unused_jmp = (jump == JMP_RST);

`ifdef PIPE2_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end
`endif

endmodule
